display_driver: RTL

DISPLAY_DRIVER -- requirements
Module: display_driver

---
 rtl/display_driver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/display_driver.sv
// Byte-to-decimal display driver: double-dabble conversion into held BCD
// registers, then a multiplexed 4-digit active-low 7-segment scan.
module display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic       busy,
  output logic [7:0] shown,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  iter_q, iter_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_val_q, pend_val_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [7:0]  shown_q, shown_d;
  logic        start;
  logic [7:0]  start_val;
  logic [11:0] bcd_adj;

  logic [CW-1:0] rcnt_q;
  logic [1:0]    idx_q;
  logic [6:0]    seg_q, digit_seg;
  logic [3:0]    an_q;

  // Add-3 correction of every BCD nibble before the shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: seg_of = 7'h40;
      4'd1: seg_of = 7'h79;
      4'd2: seg_of = 7'h24;
      4'd3: seg_of = 7'h30;
      4'd4: seg_of = 7'h19;
      4'd5: seg_of = 7'h12;
      4'd6: seg_of = 7'h02;
      4'd7: seg_of = 7'h78;
      4'd8: seg_of = 7'h00;
      4'd9: seg_of = 7'h10;
      default: seg_of = BLANK;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    shown_d    = shown_q;
    start      = 1'b0;
    start_val  = value;
    case (state_q)
      IDLE: begin
        start = load;
      end
      CONVERT: begin
        {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
        if (load) begin
          pend_vld_d = 1'b1;
          pend_val_d = value;
        end
      end
      COMMIT: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        shown_d = byte_q;
        state_d = IDLE;
        // A load arriving in this very cycle is newer than the pending one.
        if (load) begin
          start = 1'b1;
        end else if (pend_vld_q) begin
          start     = 1'b1;
          start_val = pend_val_q;
        end
        pend_vld_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = CONVERT;
      byte_d  = start_val;
      shift_d = start_val;
      bcd_d   = 12'd0;
      iter_d  = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_q     <= 8'd0;
      shift_q    <= 8'd0;
      bcd_q      <= 12'd0;
      iter_q     <= 3'd0;
      pend_vld_q <= 1'b0;
      pend_val_q <= 8'd0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      shown_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      shown_q    <= shown_d;
    end
  end

  // Leading-zero blanking; the ones digit always shows.
  always_comb begin
    digit_seg = BLANK;
    case (idx_q)
      2'd0: digit_seg = seg_of(ones_q);
      2'd1: digit_seg = (hund_q == 4'd0 && tens_q == 4'd0) ? BLANK : seg_of(tens_q);
      2'd2: digit_seg = (hund_q == 4'd0) ? BLANK : seg_of(hund_q);
      default: digit_seg = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
      idx_q  <= 2'd0;
      an_q   <= 4'b1110;
      seg_q  <= 7'h40;
    end else begin
      if (rcnt_q == LAST) begin
        rcnt_q <= '0;
        idx_q  <= idx_q + 2'd1;
      end else begin
        rcnt_q <= rcnt_q + CW'(1);
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= digit_seg;
    end
  end

  assign busy  = (state_q != IDLE);
  assign shown = shown_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule
